bcmpi_pipe: RTL and testbench

Parametrised compare-with-immediate dataflow operator for the HDS operator library: compares each accepted input token against compile-time immediate `I` under a selectable relation and emits a 1-bit result zero-extended to `N` bits. It generalises the single-stage not-equal operator with six relational modes, signed/unsigned interpretation, a configurable-depth elastic pipeline, and a full valid/ready handshake with downstream backpressure. It sits between producer and consumer operators in the generated dataflow graph.

---
 rtl/bcmpi_pipe_if.sv | 15 +
 rtl/bcmpi_pipe.sv | 134 +++++++++++++
 tb/tb_bcmpi_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcmpi_pipe_if.sv
// Token bus of the bcmpi_pipe compare operator: producer side (R_IN/D_IN/RDY_OUT)
// and consumer side (R_OUT/D_OUT/RDY_IN) of one elastic dataflow edge pair.
interface bcmpi_pipe_if #(
    parameter int N = 16
);
    logic         R_IN;
    logic         RDY_OUT;
    logic [N-1:0] D_IN;
    logic         R_OUT;
    logic         RDY_IN;
    logic [N-1:0] D_OUT;

    modport master (output R_IN, D_IN, RDY_IN, input RDY_OUT, R_OUT, D_OUT);
    modport slave  (input R_IN, D_IN, RDY_IN, output RDY_OUT, R_OUT, D_OUT);
endinterface

// File: rtl/bcmpi_pipe.sv
// Compare-with-immediate operator with a DEPTH-stage elastic valid/ready pipeline.
// Optional macro BCMPI_HIT_COUNT_EN compiles in the saturating HIT_CNT counter.
module bcmpi_pipe #(
    parameter int          N      = 16,
    parameter logic [63:0] I      = 64'd1,
    parameter int          MODE   = 1,
    parameter int          SIGNED = 0,
    parameter int          DEPTH  = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    bcmpi_pipe_if.slave bus,
    output logic [15:0] HIT_CNT
);
    localparam logic [N-1:0] IMM = I[N-1:0];

    logic [DEPTH-1:0] v_r;
    logic [DEPTH-1:0] r_r;
    logic [DEPTH-1:0] v_nxt_s;
    logic [DEPTH-1:0] r_nxt_s;
    logic [DEPTH-1:0] adv_s;
    logic             free0_s;
    logic             rdy_s;
    logic             in_xfer_s;
    logic [N-1:0]     d_out_s;

    function automatic logic cmp_f(input logic [N-1:0] a);
        logic eq_v;
        logic lt_v;
        logic res_v;
        eq_v = (a == IMM);
        if (SIGNED != 32'sd0) begin
            lt_v = ($signed(a) < $signed(IMM));
        end else begin
            lt_v = (a < IMM);
        end
        case (MODE)
            32'sd0:  res_v = eq_v;
            32'sd1:  res_v = ~eq_v;
            32'sd2:  res_v = lt_v;
            32'sd3:  res_v = lt_v | eq_v;
            32'sd4:  res_v = ~(lt_v | eq_v);
            32'sd5:  res_v = ~lt_v;
            default: res_v = 1'b0;
        endcase
        return res_v;
    endfunction

    // Ready chain from the consumer back to stage 0; a stage moves when the one after it frees up.
    always_comb begin
        logic f_v;
        logic a_v;
        adv_s = '0;
        f_v   = bus.RDY_IN;
        a_v   = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            a_v      = EN & v_r[k] & f_v;
            adv_s[k] = a_v;
            f_v      = ~v_r[k] | a_v;
        end
        free0_s = f_v;
    end

    assign rdy_s       = EN & free0_s;
    assign in_xfer_s   = bus.R_IN & rdy_s;
    assign bus.RDY_OUT = rdy_s;

    // Next-state of each stage: load from upstream, drain when emptied, otherwise hold.
    always_comb begin
        v_nxt_s = v_r;
        r_nxt_s = r_r;
        if (in_xfer_s) begin
            v_nxt_s[0] = 1'b1;
            r_nxt_s[0] = cmp_f(bus.D_IN);
        end else if (adv_s[0]) begin
            v_nxt_s[0] = 1'b0;
        end else begin
            v_nxt_s[0] = v_r[0];
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (adv_s[k-1]) begin
                v_nxt_s[k] = 1'b1;
                r_nxt_s[k] = r_r[k-1];
            end else if (adv_s[k]) begin
                v_nxt_s[k] = 1'b0;
            end else begin
                v_nxt_s[k] = v_r[k];
            end
        end
    end

    // Stage valid/result registers; EN=0 already forces the next state to equal the current one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v_r <= '0;
            r_r <= '0;
        end else begin
            v_r <= v_nxt_s;
            r_r <= r_nxt_s;
        end
    end

    // Result is zero-extended from the last stage's registered bit.
    always_comb begin
        d_out_s    = '0;
        d_out_s[0] = r_r[DEPTH-1];
    end

    assign bus.R_OUT = v_r[DEPTH-1];
    assign bus.D_OUT = d_out_s;

`ifdef BCMPI_HIT_COUNT_EN
    logic [15:0] hit_cnt_r;
    logic        out_xfer_s;

    assign out_xfer_s = adv_s[DEPTH-1];

    // Saturating count of delivered tokens whose result is 1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_r <= 16'h0000;
        end else if (out_xfer_s && r_r[DEPTH-1] && (hit_cnt_r != 16'hFFFF)) begin
            hit_cnt_r <= hit_cnt_r + 16'd1;
        end else begin
            hit_cnt_r <= hit_cnt_r;
        end
    end

    assign HIT_CNT = hit_cnt_r;
`else
    assign HIT_CNT = 16'h0000;
`endif
endmodule

// File: tb/tb_bcmpi_pipe.sv
// Bench for bcmpi_pipe: four DEPTH=2 lanes (relation/sign variants) and one DEPTH=3 GE instance.
module tb_bcmpi_pipe;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic       EN;
    logic       a_r_in, a_rdy;
    logic [7:0] a_d;
    logic       b_r_in, b_rdy;
    logic [7:0] b_d;
    logic [3:0] a_rv, a_rdyo;
    logic [7:0] a_dout [4];
    logic [15:0] hit_a [4];
    logic [15:0] hit_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_a [4][$];
    bit exp_b [$];

    localparam int MODE_TAB [4] = '{2, 2, 5, 1};
    localparam int SGN_TAB  [4] = '{0, 1, 0, 0};

    for (genvar g = 0; g < 4; g++) begin : lane
        bcmpi_pipe_if #(.N(8)) bus ();
        assign bus.R_IN   = a_r_in;
        assign bus.D_IN   = a_d;
        assign bus.RDY_IN = a_rdy;
        assign a_rv[g]    = bus.R_OUT;
        assign a_rdyo[g]  = bus.RDY_OUT;
        assign a_dout[g]  = bus.D_OUT;
        bcmpi_pipe #(.N(8), .I(64'h80), .MODE(MODE_TAB[g]), .SIGNED(SGN_TAB[g]), .DEPTH(2)) u_dut (
            .CLK(CLK), .RST(RST), .EN(EN), .bus(bus), .HIT_CNT(hit_a[g])
        );
    end

    bcmpi_pipe_if #(.N(8)) bus_b ();
    assign bus_b.R_IN   = b_r_in;
    assign bus_b.D_IN   = b_d;
    assign bus_b.RDY_IN = b_rdy;
    bcmpi_pipe #(.N(8), .I(64'h80), .MODE(5), .SIGNED(0), .DEPTH(3)) u_dut_b (
        .CLK(CLK), .RST(RST), .EN(EN), .bus(bus_b), .HIT_CNT(hit_b)
    );

    function automatic bit model_b(input logic [7:0] d);
        return d >= 8'h80;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard for the DEPTH=3 instance: push on input transfer, pop and compare on output transfer.
    always @(negedge CLK) begin
        bit e;
        if (RST) begin
            exp_b.delete();
        end else if (EN) begin
            if (bus_b.R_OUT && b_rdy) begin
                n_checks++;
                if (exp_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: token with D_OUT=%0h delivered, none expected", bus_b.D_OUT);
                end else begin
                    e = exp_b.pop_front();
                    if (bus_b.D_OUT !== {7'b0, e}) begin
                        n_fail++;
                        $display("FAIL sb_data: D_OUT=%0h expected %0h", bus_b.D_OUT, {7'b0, e});
                    end
                end
            end
            if (b_r_in && bus_b.RDY_OUT) exp_b.push_back(model_b(b_d));
        end
    end

    task automatic test_reset();
        RST = 1'b1; EN = 1'b1;
        a_r_in = 1'b1; a_d = 8'd5; a_rdy = 1'b1;
        b_r_in = 1'b1; b_d = 8'd5; b_rdy = 1'b1;
        repeat (2) begin
            tick();
            n_checks++;
            if (bus_b.R_OUT !== 1'b0 || bus_b.D_OUT !== 8'h00 || hit_b !== 16'h0000 || a_rv !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_state: R_OUT=%b D_OUT=%0h HIT=%0h lanes=%b expected 0", bus_b.R_OUT, bus_b.D_OUT, hit_b, a_rv);
            end
        end
        RST = 1'b0; a_r_in = 1'b0; b_r_in = 1'b0;
        #1;
        n_checks++;
        if (bus_b.RDY_OUT !== 1'b1 || a_rdyo !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_rdy: RDY_OUT=%b lanes=%b expected 1", bus_b.RDY_OUT, a_rdyo);
        end
        repeat (4) begin
            tick();
            n_checks++;
            if (bus_b.R_OUT !== 1'b0 || a_rv !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_idle: R_OUT=%b lanes=%b expected 0", bus_b.R_OUT, a_rv);
            end
        end
    endtask

    task automatic test_modes();
        logic [7:0] tok [3];
        bit exp_tab [4][3];
        bit e;
        tok = '{8'h7F, 8'h80, 8'h81};
        exp_tab = '{'{1'b1, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1}, '{1'b1, 1'b0, 1'b1}};
        a_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            a_r_in = (c < 3);
            a_d    = (c < 3) ? tok[c] : 8'h00;
            #1;
            if (c < 3) begin
                n_checks++;
                if (a_rdyo !== 4'hF) begin
                    n_fail++;
                    $display("FAIL mode_rdy: cycle %0d RDY_OUT=%b expected 1111", c, a_rdyo);
                end
                for (int g = 0; g < 4; g++) exp_a[g].push_back(exp_tab[g][c]);
            end
            tick();
            for (int g = 0; g < 4; g++) begin
                n_checks++;
                if (a_rv[g] !== ((c >= 1 && c <= 3) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL mode_latency: lane %0d cycle %0d R_OUT=%b expected %b", g, c, a_rv[g], (c >= 1 && c <= 3));
                end
                if (a_rv[g] === 1'b1 && exp_a[g].size() != 0) begin
                    e = exp_a[g].pop_front();
                    n_checks++;
                    if (a_dout[g] !== {7'b0, e}) begin
                        n_fail++;
                        $display("FAIL mode_result: lane %0d D_OUT=%0h expected %0h", g, a_dout[g], {7'b0, e});
                    end
                end
            end
        end
        a_r_in = 1'b0;
    endtask

    task automatic test_backpressure_back_to_back();
        logic [7:0] toks [8];
        logic [7:0] snap;
        int sent = 0;
        int got  = 0;
        toks = '{8'h10, 8'h90, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h81, 8'hC3};
        snap = 8'h00;
        b_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            b_r_in = 1'b1; b_d = toks[sent];
            #1;
            if (c >= 3) begin
                n_checks++;
                if (bus_b.RDY_OUT !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_rdy_drop: cycle %0d RDY_OUT=%b expected 0", c, bus_b.RDY_OUT);
                end
            end
            if (bus_b.RDY_OUT === 1'b1) sent++;
            tick();
            if (c == 2) snap = bus_b.D_OUT;
            if (c >= 3) begin
                n_checks++;
                if (bus_b.R_OUT !== 1'b1 || bus_b.D_OUT !== snap) begin
                    n_fail++;
                    $display("FAIL bp_stable: R_OUT=%b D_OUT=%0h expected 1 / %0h", bus_b.R_OUT, bus_b.D_OUT, snap);
                end
            end
        end
        n_checks++;
        if (sent !== 3) begin
            n_fail++;
            $display("FAIL bp_accepts: accepted %0d expected 3", sent);
        end
        b_rdy = 1'b1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            b_r_in = (sent < 8);
            b_d    = (sent < 8) ? toks[sent] : 8'h00;
            #1;
            n_checks++;
            if (bus_b.R_OUT !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_gap: R_OUT=%b expected 1 after %0d delivered", bus_b.R_OUT, got);
            end
            if (sent < 8) begin
                n_checks++;
                if (bus_b.RDY_OUT !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_rdy: full pipe RDY_OUT=%b expected 1", bus_b.RDY_OUT);
                end
            end
            if (bus_b.R_OUT === 1'b1) got++;
            if (b_r_in && bus_b.RDY_OUT === 1'b1) sent++;
            tick();
        end
        b_r_in = 1'b0;
        n_checks++;
        if (got !== 8 || sent !== 8 || exp_b.size() != 0 || bus_b.R_OUT !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d sent %0d left %0d R_OUT=%b expected 8 8 0 0", got, sent, exp_b.size(), bus_b.R_OUT);
        end
    endtask

    task automatic test_enable_freeze();
        logic       snap_v;
        logic [7:0] snap_d;
        logic [15:0] snap_h;
        int got = 0;
        b_rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            b_r_in = 1'b1; b_d = (c == 0) ? 8'hA5 : 8'h05;
            tick();
        end
        b_r_in = 1'b0;
        repeat (2) tick();
        snap_v = bus_b.R_OUT; snap_d = bus_b.D_OUT; snap_h = hit_b;
        n_checks++;
        if (snap_v !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze_fill: R_OUT=%b expected 1", snap_v);
        end
        EN = 1'b0; b_rdy = 1'b1; b_r_in = 1'b1; b_d = 8'hFF;
        repeat (4) begin
            #1;
            n_checks++;
            if (bus_b.RDY_OUT !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze_rdy: RDY_OUT=%b expected 0", bus_b.RDY_OUT);
            end
            tick();
            n_checks++;
            if (bus_b.R_OUT !== snap_v || bus_b.D_OUT !== snap_d || hit_b !== snap_h) begin
                n_fail++;
                $display("FAIL freeze_hold: R_OUT=%b D_OUT=%0h HIT=%0h expected %b %0h %0h", bus_b.R_OUT, bus_b.D_OUT, hit_b, snap_v, snap_d, snap_h);
            end
        end
        EN = 1'b1; b_r_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus_b.R_OUT === 1'b1) got++;
            tick();
        end
        n_checks++;
        if (got !== 2 || exp_b.size() != 0) begin
            n_fail++;
            $display("FAIL freeze_resume: delivered %0d left %0d expected 2 0", got, exp_b.size());
        end
    endtask

    task automatic test_reset_mid();
        b_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            b_r_in = 1'b1; b_d = 8'hFF;
            tick();
        end
        b_r_in = 1'b0;
        n_checks++;
        if (bus_b.R_OUT !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_fill: R_OUT=%b expected 1", bus_b.R_OUT);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if (bus_b.R_OUT !== 1'b0 || bus_b.D_OUT !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_flush: R_OUT=%b D_OUT=%0h expected 0 0", bus_b.R_OUT, bus_b.D_OUT);
        end
        b_rdy = 1'b1;
        repeat (8) begin
            tick();
            n_checks++;
            if (bus_b.R_OUT !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_ghost: R_OUT=%b expected 0", bus_b.R_OUT);
            end
        end
    endtask

    task automatic test_counter();
`ifdef BCMPI_HIT_COUNT_EN
        int sent = 0;
        int got  = 0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        b_rdy = 1'b1; b_d = 8'hFF;
        for (int c = 0; c < 70100 && got < 70000; c++) begin
            b_r_in = (sent < 70000);
            #1;
            if (bus_b.R_OUT === 1'b1) got++;
            if (b_r_in && bus_b.RDY_OUT === 1'b1) sent++;
            tick();
            if (got == 100 && bus_b.R_OUT === 1'b1 && c < 103) begin
                n_checks++;
                if (hit_b !== 16'd100) begin
                    n_fail++;
                    $display("FAIL cnt_partial: HIT_CNT=%0d expected 100", hit_b);
                end
            end
        end
        b_r_in = 1'b0;
        n_checks++;
        if (got !== 70000 || hit_b !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_saturate: delivered %0d HIT_CNT=%0d expected 70000 65535", got, hit_b);
        end
`else
        b_rdy = 1'b1; b_d = 8'hFF;
        for (int c = 0; c < 12; c++) begin
            b_r_in = (c < 5);
            tick();
            n_checks++;
            if (hit_b !== 16'h0000) begin
                n_fail++;
                $display("FAIL cnt_tied: HIT_CNT=%0h expected 0", hit_b);
            end
        end
        b_r_in = 1'b0;
        n_checks++;
        if (exp_b.size() != 0) begin
            n_fail++;
            $display("FAIL cnt_drain: %0d tokens outstanding expected 0", exp_b.size());
        end
`endif
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; EN = 1'b1;
        a_r_in = 1'b0; a_d = 8'h00; a_rdy = 1'b1;
        b_r_in = 1'b0; b_d = 8'h00; b_rdy = 1'b1;
        test_reset();
        test_modes();
        test_backpressure_back_to_back();
        test_enable_freeze();
        test_reset_mid();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
